// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//
// Arbitrates four byte-wide requesters onto the write side of a single FIFO.
// A requester that wins arbitration owns the FIFO write port for a burst of
// up to BURST_LEN words. The burst ends early if the owner stops requesting.
// It pauses while the FIFO reports almost_full. It is abandoned if the FIFO
// enters write reset.
//
// Build option:
//   FIFO_WR_ARB_FIXED_PRI_EN  defined   -> fixed priority, req[0] highest,
//                                          no round-robin pointer
//                             undefined -> round-robin, search starts one
//                                          past the previous owner
//
// Parameters:
//   BURST_LEN     maximum words per grant (1..255)
//
// Ports:
//   wr_clk        write clock; the whole block runs in this domain
//   rst_n         asynchronous active-low reset
//   req[3:0]      per-requester word-valid
//   req_data[31:0] packed words, requester i on bits [8i+7:8i]
//   almost_full   FIFO almost-full flag; pauses an active burst
//   wr_rst_busy   FIFO write-reset busy; blocks all writes
//   gnt[3:0]      one-hot combinational grant
//   owner[1:0]    current or most recent owner (registered)
//   fifo_wr_en    FIFO write enable (registered)
//   fifo_wr_data  FIFO write data (registered, holds between writes)
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int unsigned BURST_LEN = 16
) (
  input  logic        wr_clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic        almost_full,
  input  logic        wr_rst_busy,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    IDLE     = 2'd1,
    GRANT    = 2'd2
  } state_t;

  // Count value of the final word of a full-length burst.
  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 32'd1);

  state_t      state_r;
  logic [1:0]  owner_r;
  logic [7:0]  cnt_r;
  logic        fifo_wr_en_r;
  logic [7:0]  fifo_wr_data_r;

  logic        grant_ok_s;
  logic [3:0]  gnt_s;
  logic        xfer_s;
  logic [7:0]  owner_byte_s;
  logic [1:0]  winner_s;

`ifdef FIFO_WR_ARB_FIXED_PRI_EN

  // Lowest-indexed active requester wins.
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] win;
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) begin
        win = 2'(k);
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  // Winner selection for the fixed-priority build.
  always_comb begin
    winner_s = pick_fixed(req);
  end

`else

  // Search start for the next arbitration. It points one past the last
  // owner, which keeps continuously-requesting sources from starving.
  logic [1:0]  ptr_r;

  // First active requester found when scanning upward (mod 4) from start.
  function automatic logic [1:0] pick_rr(input logic [3:0] r,
                                         input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

  // Winner selection for the round-robin build.
  always_comb begin
    winner_s = pick_rr(req, ptr_r);
  end

  // Round-robin pointer; it advances whenever a new burst is granted.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 2'd0;
    end else if (!wr_rst_busy && (state_r == IDLE) && (|req) && !almost_full) begin
      ptr_r <= winner_s + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`endif

  // Grant decode and transfer qualification. Grant drops at once when the
  // FIFO fills or enters reset, so no word is lost in those cycles.
  always_comb begin
    grant_ok_s = (state_r == GRANT) && !almost_full && !wr_rst_busy;
    gnt_s      = 4'b0000;
    if (grant_ok_s) begin
      gnt_s[owner_r] = 1'b1;
    end else begin
      gnt_s = 4'b0000;
    end
    xfer_s       = grant_ok_s && req[owner_r];
    owner_byte_s = req_data[{owner_r, 3'b000} +: 8];
  end

  // Main control FSM, including the registered FIFO write port.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= RST_WAIT;
      owner_r        <= 2'd0;
      cnt_r          <= 8'd0;
      fifo_wr_en_r   <= 1'b0;
      fifo_wr_data_r <= 8'h00;
    end else begin
      fifo_wr_en_r <= xfer_s;
      if (xfer_s) begin
        fifo_wr_data_r <= owner_byte_s;
      end else begin
        fifo_wr_data_r <= fifo_wr_data_r;
      end

      if (wr_rst_busy) begin
        // FIFO reset overrides everything; the owner is kept for visibility.
        state_r <= RST_WAIT;
        cnt_r   <= 8'd0;
      end else begin
        case (state_r)
          RST_WAIT: begin
            state_r <= IDLE;
          end
          IDLE: begin
            if ((|req) && !almost_full) begin
              state_r <= GRANT;
              owner_r <= winner_s;
              cnt_r   <= 8'd0;
            end else begin
              state_r <= IDLE;
            end
          end
          GRANT: begin
            if (almost_full) begin
              // Pause: state, owner and count all hold.
              state_r <= GRANT;
            end else if (xfer_s) begin
              if (cnt_r == LAST_CNT) begin
                state_r <= IDLE;
              end else begin
                cnt_r <= cnt_r + 8'd1;
              end
            end else begin
              // Owner stopped requesting: release the FIFO early.
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= RST_WAIT;
            cnt_r   <= 8'd0;
          end
        endcase
      end
    end
  end

  assign gnt          = gnt_s;
  assign owner        = owner_r;
  assign fifo_wr_en   = fifo_wr_en_r;
  assign fifo_wr_data = fifo_wr_data_r;

endmodule
